// File: rtl/pingpong_fb_pkg.sv
// pingpong_fb_pkg
// Shared definitions for the ping-pong frame buffer.
//   wr_state_t : states of the write-side frame-capture FSM
//   DROP_W     : width of the saturating dropped-frame counter
//   DROP_MAX   : saturation value of that counter
package pingpong_fb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DONE = 2'd2
  } wr_state_t;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/fb_bank_ram.sv
// fb_bank_ram
// Single-clock simple dual-port RAM holding both frame banks. The bank index
// is the address MSB, so each bank occupies one half of the array. Read is
// synchronous with an enable, which keeps the structure block-RAM friendly.
// Contents are never reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : {bank, pixel address} for the write port
//   wr_data : pixel to store
//   rd_en   : read strobe, rd_data updates the cycle after
//   rd_addr : {bank, pixel address} for the read port
//   rd_data : registered read pixel
module fb_bank_ram #(
  parameter int DATA_W = 12,
  parameter int AW     = 18
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**AW];

  // Write port and registered read port share the one clock; no reset so the
  // array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// pingpong_frame_buffer
// Double-buffered frame store. The writer fills the back bank with a whole
// frame; the reader scans the front bank. A finished back frame becomes the
// front frame at the next display start-of-frame.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_valid    : pixel present on wr_data
//   wr_sof      : the wr_valid pixel is the first of a frame
//   wr_data     : write pixel
//   rd_en       : request next display pixel
//   rd_sof      : the rd_en request is the first pixel of a display frame
//   rd_valid    : rd_data valid (one cycle after rd_en)
//   rd_data     : read pixel, zero while no frame has been shown
//   frame_valid : front bank holds a complete frame
//   front_bank  : bank currently read
//   drop_cnt    : dropped input frames, saturating
module pingpong_frame_buffer
  import pingpong_fb_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_sof,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic              front_bank,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int NPIX = H_RES * V_RES;
  localparam int ADDR_W = $clog2(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  wr_state_t         state, state_next;
  logic [ADDR_W-1:0] wr_addr, wr_addr_next, mem_wr_addr;
  logic              front_next, frame_valid_next;
  logic              drop_latched, drop_latched_next;
  logic              drop_inc, mem_wr_en, swap, wr_start;
  logic [DROP_W-1:0] drop_cnt_next;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_next, mem_rd_addr;
  logic              rd_live;
  logic [DATA_W-1:0] ram_q;

  assign wr_start = wr_valid & wr_sof;

  // Write FSM next-state logic. A swap can only happen when W_DONE was already
  // registered, so a frame completing on an rd_sof cycle waits for the next
  // rd_sof. drop_latched makes only the first new sof during W_DONE count.
  always_comb begin
    state_next        = state;
    wr_addr_next      = wr_addr;
    front_next        = front_bank;
    frame_valid_next  = frame_valid;
    drop_latched_next = drop_latched;
    drop_inc          = 1'b0;
    mem_wr_en         = 1'b0;
    mem_wr_addr       = '0;
    swap              = rd_en & rd_sof & (state == W_DONE);
    case (state)
      W_IDLE: begin
        if (wr_start) begin
          mem_wr_en    = 1'b1;
          wr_addr_next = ADDR_W'(1);
          state_next   = W_FILL;
        end
      end
      W_FILL: begin
        if (wr_valid) begin
          mem_wr_en = 1'b1;
          if (wr_sof) begin
            // Short frame: restart at pixel 0 and count the lost one.
            drop_inc     = 1'b1;
            wr_addr_next = ADDR_W'(1);
          end else begin
            mem_wr_addr = wr_addr;
            if (wr_addr == LAST_ADDR) begin
              wr_addr_next      = '0;
              drop_latched_next = 1'b0;
              state_next        = W_DONE;
            end else begin
              wr_addr_next = wr_addr + 1'b1;
            end
          end
        end
      end
      W_DONE: begin
        if (swap) begin
          front_next       = ~front_bank;
          frame_valid_next = 1'b1;
          state_next       = W_IDLE;
          if (wr_start) begin
            // New frame starts straight into the bank just released.
            mem_wr_en    = 1'b1;
            wr_addr_next = ADDR_W'(1);
            state_next   = W_FILL;
          end
        end else if (wr_start && !drop_latched) begin
          drop_inc          = 1'b1;
          drop_latched_next = 1'b1;
        end
      end
      default: state_next = W_IDLE;
    endcase
    drop_cnt_next = (drop_inc && (drop_cnt != DROP_MAX)) ? drop_cnt + 1'b1 : drop_cnt;
  end

  // Write-side and bank-selection registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= W_IDLE;
      wr_addr      <= '0;
      front_bank   <= 1'b0;
      frame_valid  <= 1'b0;
      drop_latched <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_next;
      wr_addr      <= wr_addr_next;
      front_bank   <= front_next;
      frame_valid  <= frame_valid_next;
      drop_latched <= drop_latched_next;
      drop_cnt     <= drop_cnt_next;
    end
  end

  // Read address: rd_sof restarts at pixel 0, otherwise the stored pointer is
  // used; the pointer wraps at the end of the frame.
  always_comb begin
    mem_rd_addr = rd_sof ? '0 : rd_ptr;
    rd_ptr_next = rd_ptr;
    if (rd_en) begin
      rd_ptr_next = (mem_rd_addr == LAST_ADDR) ? '0 : mem_rd_addr + 1'b1;
    end
  end

  // Read-side registers. rd_live remembers whether the read was from a valid
  // frame, which gates the un-reset RAM output to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_live  <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_next;
      rd_valid <= rd_en;
      rd_live  <= rd_en & frame_valid_next;
    end
  end

  assign rd_data = rd_live ? ram_q : '0;

  // Both ports use the post-swap bank, so reader and writer always sit in
  // opposite halves of the RAM.
  fb_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr ({~front_next, mem_wr_addr}),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr ({front_next, mem_rd_addr}),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// tb_pingpong_frame_buffer
// Self-checking bench for pingpong_frame_buffer (4x2 pixel frames). A
// frame-level reference model predicts read data and status; read
// expectations go into a scoreboard queue drained by a separate monitor.
module tb_pingpong_frame_buffer;

  localparam int DATA_W = 12;
  localparam int H_RES  = 4;
  localparam int V_RES  = 2;
  localparam int NPIX   = H_RES * V_RES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_sof = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic              rd_sof = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              frame_valid;
  logic              front_bank;
  logic [7:0]        drop_cnt;

  pingpong_frame_buffer #(
    .DATA_W (DATA_W),
    .H_RES  (H_RES),
    .V_RES  (V_RES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_sof      (wr_sof),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_sof      (rd_sof),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .front_bank  (front_bank),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frames as whole pixel arrays/queues.
  logic [DATA_W-1:0] m_show  [NPIX];
  logic [DATA_W-1:0] m_ready [NPIX];
  logic [DATA_W-1:0] m_part  [$];
  bit m_fv, m_front, m_has_ready, m_building, m_dropped;
  int m_rptr, m_drop;

  task automatic checkValue(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic modelReset();
    m_fv = 0; m_front = 0; m_has_ready = 0; m_building = 0; m_dropped = 0;
    m_rptr = 0; m_drop = 0;
    m_part.delete();
    for (int i = 0; i < NPIX; i++) begin
      m_show[i] = '0;
      m_ready[i] = '0;
    end
  endtask

  task automatic bumpDrop();
    if (m_drop < 255) m_drop++;
  endtask

  // One clock of the reference model; pushes the read expectation if any.
  task automatic modelStep(input bit wv, input bit ws, input logic [DATA_W-1:0] wd,
                           input bit re, input bit rs);
    bit   swap;
    int   addr;
    exp_t e;
    swap = re && rs && m_has_ready;
    if (swap) begin
      m_show = m_ready;
      m_fv = 1;
      m_front = !m_front;
      m_has_ready = 0;
    end
    if (re) begin
      addr = rs ? 0 : m_rptr;
      m_rptr = (addr + 1) % NPIX;
      e.data = m_fv ? m_show[addr] : '0;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    if (swap) begin
      if (wv && ws) begin
        m_part = {wd};
        m_building = 1;
      end
    end else if (m_has_ready) begin
      if (wv && ws && !m_dropped) begin
        bumpDrop();
        m_dropped = 1;
      end
    end else if (m_building) begin
      if (wv) begin
        if (ws) begin
          bumpDrop();
          m_part = {wd};
        end else begin
          m_part.push_back(wd);
        end
        if (m_part.size() == NPIX) begin
          for (int i = 0; i < NPIX; i++) m_ready[i] = m_part[i];
          m_has_ready = 1;
          m_building = 0;
          m_dropped = 0;
        end
      end
    end else if (wv && ws) begin
      m_part = {wd};
      m_building = 1;
    end
  endtask

  task automatic checkOutput();
    checkValue("frame_valid", int'(frame_valid), int'(m_fv));
    checkValue("front_bank", int'(front_bank), int'(m_front));
    checkValue("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // Drive one cycle of inputs, advance the model, then check status.
  task automatic applyStimulus(input bit wv, input bit ws, input logic [DATA_W-1:0] wd,
                               input bit re, input bit rs);
    wr_valid = wv; wr_sof = ws; wr_data = wd; rd_en = re; rd_sof = rs;
    modelStep(wv, ws, wd, re, rs);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0);
  endtask

  task automatic writeFrame(input int base, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, i == 0, DATA_W'(base + i), 0, 0);
  endtask

  task automatic readFrame(input int n);
    applyStimulus(0, 0, '0, 1, 1);
    for (int i = 1; i < n; i++) applyStimulus(0, 0, '0, 1, 0);
  endtask

  // Asynchronous reset placed between clock edges; outputs must clear at once.
  task automatic resetDut();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    wr_valid = 0; wr_sof = 0; rd_en = 0; rd_sof = 0;
    #1;
    checkValue("rst_rd_valid", int'(rd_valid), 0);
    checkValue("rst_rd_data", int'(rd_data), 0);
    checkValue("rst_frame_valid", int'(frame_valid), 0);
    checkValue("rst_front_bank", int'(front_bank), 0);
    checkValue("rst_drop_cnt", int'(drop_cnt), 0);
    modelReset();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle out of reset, compare rd_valid against the
  // scoreboard head and pop its data when a response is due.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      bit due;
      due = (sb.size() > 0) && (sb[0].cyc == cyc);
      checkValue("rd_valid", int'(rd_valid), int'(due));
      if (due) begin
        e = sb.pop_front();
        checkValue("rd_data", int'(rd_data), int'(e.data));
      end
    end
  end

  initial begin
    int d0;
    bit f0;
    bit wv, ws, re, rs;

    modelReset();
    #12;
    checkValue("init_rd_valid", int'(rd_valid), 0);
    checkValue("init_rd_data", int'(rd_data), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reads with no frame shown return zero.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 0);
    idle(2);

    // First frame, swap and read back including the wrap.
    writeFrame(12'h001, NPIX);
    idle(1);
    readFrame(NPIX);
    applyStimulus(0, 0, '0, 1, 0);
    checkValue("front_after_swap", int'(front_bank), 1);
    checkValue("fv_after_swap", int'(frame_valid), 1);
    idle(1);

    // Short frame restarts and is counted.
    writeFrame(12'h0A0, 3);
    writeFrame(12'h010, NPIX);
    checkValue("drop_short", int'(drop_cnt), 1);
    readFrame(NPIX);

    // Full frame B while A is waiting: B dropped, A shown.
    d0 = int'(drop_cnt);
    writeFrame(12'h100, NPIX);
    writeFrame(12'h200, NPIX);
    checkValue("drop_frozen", int'(drop_cnt), d0 + 1);
    readFrame(NPIX);

    // Completion coincident with rd_sof does not swap.
    f0 = front_bank;
    writeFrame(12'h300, NPIX - 1);
    applyStimulus(1, 0, 12'h307, 1, 1);
    checkValue("no_swap_on_done", int'(front_bank), int'(f0));
    applyStimulus(0, 0, '0, 1, 1);
    checkValue("swap_next_sof", int'(front_bank), int'(!f0));
    for (int i = 1; i < NPIX; i++) applyStimulus(0, 0, '0, 1, 0);

    // Swap cycle accepts a new frame start without a drop.
    writeFrame(12'h400, NPIX);
    d0 = int'(drop_cnt);
    applyStimulus(1, 1, 12'h500, 1, 1);
    for (int i = 1; i < NPIX; i++) applyStimulus(1, 0, DATA_W'(12'h500 + i), 1, 0);
    checkValue("no_drop_on_swap", int'(drop_cnt), d0);
    readFrame(NPIX);

    // Reset in the middle of a fill.
    for (int i = 0; i < 5; i++) applyStimulus(1, i == 0, DATA_W'(12'h600 + i), 1, 0);
    resetDut();
    idle(1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      wv = ($urandom % 10) < 7;
      ws = wv && (($urandom % 10) == 0);
      re = ($urandom % 10) < 6;
      rs = re && (($urandom % 12) == 0);
      applyStimulus(wv, ws, DATA_W'($urandom), re, rs);
    end

    // Saturate the drop counter with back-to-back short frames.
    applyStimulus(0, 0, '0, 1, 1);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, DATA_W'($urandom), 0, 0);
    checkValue("drop_saturated", int'(drop_cnt), 255);

    idle(3);
    checkValue("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
